// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared memory port: fetch vs data, data-priority with a fetch starvation guard.
// Latency: issue in the request cycle when idle, done strobe LAT cycles later, one idle bubble between transactions.
// Backpressure: losing or waiting requester sees its stall held until its done strobe; requests never re-sampled while busy.
module mem_arbiter #(
    parameter int LAT         = 4,
    parameter int MAX_DSTREAK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_cancel,
    output logic        if_done,
    output logic [15:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        d_stall,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [3:0] LAT_C  = 4'(LAT);
    localparam logic [2:0] MAXD_C = 3'(MAX_DSTREAK);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] dstreak, dstreak_nxt;
    logic       drop, drop_nxt;

    logic grant_d, grant_i, last_cyc;

    // Data wins a tie unless it has already taken MAX_DSTREAK grants in a row while fetch waited.
    assign grant_d  = (state == IDLE) && d_req && (!if_req || (dstreak != MAXD_C));
    assign grant_i  = (state == IDLE) && if_req && !grant_d;
    assign last_cyc = (state != IDLE) && (cnt == LAT_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            dstreak <= 3'd0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dstreak <= dstreak_nxt;
            drop    <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dstreak_nxt = dstreak;
        drop_nxt    = drop;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt   = BUSY_D;
                    cnt_nxt     = 4'd1;
                    dstreak_nxt = !if_req ? 3'd0 :
                                  (dstreak == MAXD_C) ? dstreak : dstreak + 3'd1;
                end else if (grant_i) begin
                    state_nxt   = BUSY_I;
                    cnt_nxt     = 4'd1;
                    dstreak_nxt = 3'd0;
                    drop_nxt    = if_cancel;
                end
            end
            BUSY_I: begin
                if (last_cyc) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                    drop_nxt  = 1'b0;
                end else begin
                    cnt_nxt  = cnt + 4'd1;
                    drop_nxt = drop | if_cancel;
                end
            end
            BUSY_D: begin
                if (last_cyc) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = if_addr;
        mem_data_in = d_wdata;
        if_done     = 1'b0;
        d_done      = 1'b0;
        case (state)
            IDLE: begin
                mem_enable = grant_d | grant_i;
                if (grant_d) begin
                    mem_wr   = d_wr;
                    mem_addr = d_addr;
                end
            end
            BUSY_I: begin
                if_done = last_cyc && !drop && !if_cancel;
            end
            BUSY_D: begin
                mem_wr   = d_wr;
                mem_addr = d_addr;
                d_done   = last_cyc;
            end
            default: begin
                mem_enable = 1'b0;
            end
        endcase
        if_stall = if_req & ~if_done;
        d_stall  = d_req & ~d_done;
        // Reset silences every control output immediately, whatever the requesters do.
        if (rst) begin
            mem_enable = 1'b0;
            mem_wr     = 1'b0;
            if_done    = 1'b0;
            d_done     = 1'b0;
            if_stall   = 1'b0;
            d_stall    = 1'b0;
        end
    end

    assign if_rdata = mem_data_out;
    assign d_rdata  = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LAT=4, MAX_DSTREAK=2).
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_cancel, d_req, d_wr;
    logic [15:0] if_addr, d_addr, d_wdata, mem_data_out;
    logic        if_done, if_stall, d_done, d_stall, mem_enable, mem_wr;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_data_in;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(4), .MAX_DSTREAK(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_wr = 1'b1; if_cancel = 1'b0;
        if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; mem_data_out = 16'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_enable, mem_wr, if_done, d_done, if_stall, d_stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 000000",
                     {mem_enable, mem_wr, if_done, d_done, if_stall, d_stall});
        end
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_enable, mem_wr, if_done, d_done, if_stall, d_stall} !== 6'b0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL idle_after_reset got %b addr %h required 000000 addr 0000",
                     {mem_enable, mem_wr, if_done, d_done, if_stall, d_stall}, mem_addr);
        end
        next_cycle();
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 16'h0010; mem_data_out = 16'hA5A5;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_enable !== (c == 0) || if_done !== (c == 4) || if_stall !== (c < 4)
                || mem_addr !== 16'h0010 || d_done !== 1'b0) begin
                errors++;
                $display("FAIL fetch c=%0d got en %b done %b stall %b addr %h required en %b done %b stall %b addr 0010",
                         c, mem_enable, if_done, if_stall, mem_addr, c == 0, c == 4, c < 4);
            end
            if (c == 4) begin
                checks++;
                if (if_rdata !== 16'hA5A5) begin
                    errors++;
                    $display("FAIL fetch_rdata got %h required a5a5", if_rdata);
                end
            end
            next_cycle();
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_enable !== 1'b0 || if_stall !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle got en %b stall %b required 0 0", mem_enable, if_stall);
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 16'h0020; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
        mem_data_out = 16'h5A5A;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (mem_enable !== (c == 0 || c == 5) || d_done !== (c == 4) || if_done !== (c == 9)
                || mem_addr !== ((c < 5) ? 16'h0100 : 16'h0020)) begin
                errors++;
                $display("FAIL simul c=%0d got en %b d_done %b if_done %b addr %h",
                         c, mem_enable, d_done, if_done, mem_addr);
            end
            if (c == 4) begin
                checks++;
                if (d_rdata !== 16'h5A5A || if_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_data got rdata %h if_stall %b required 5a5a 1", d_rdata, if_stall);
                end
            end
            next_cycle();
            if (c == 4) d_req = 1'b0;
            if (c == 9) if_req = 1'b0;
        end
    endtask

    task automatic test_starvation();
        logic exp_en;
        logic [15:0] exp_addr;
        if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        for (int c = 0; c <= 25; c++) begin
            @(negedge clk);
            exp_en = (c % 5 == 0);
            exp_addr = (c >= 10 && c < 15) || c >= 25 ? 16'h0040 : 16'h0300;
            checks++;
            if (mem_enable !== exp_en || mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL starve c=%0d got en %b addr %h required en %b addr %h",
                         c, mem_enable, mem_addr, exp_en, exp_addr);
            end
            next_cycle();
        end
        d_req = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (if_done !== 1'b1) begin
            errors++;
            $display("FAIL starve_fetch_done got %b required 1", if_done);
        end
        next_cycle();
        if_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_write();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_enable !== (c == 0) || mem_wr !== 1'b1 || mem_data_in !== 16'h1234
                || mem_addr !== 16'h0200 || d_done !== (c == 4) || d_stall !== (c < 4)) begin
                errors++;
                $display("FAIL write c=%0d got en %b wr %b din %h addr %h done %b stall %b",
                         c, mem_enable, mem_wr, mem_data_in, mem_addr, d_done, d_stall);
            end
            next_cycle();
        end
        d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b0 || mem_enable !== 1'b0) begin
            errors++;
            $display("FAIL write_idle got wr %b en %b required 0 0", mem_wr, mem_enable);
        end
        next_cycle();
    endtask

    task automatic test_cancel();
        if_req = 1'b1; if_addr = 16'h0050; mem_data_out = 16'hBEEF;
        for (int c = 0; c <= 9; c++) begin
            if (c == 2) if_cancel = 1'b1;
            if (c == 3) if_cancel = 1'b0;
            if (c == 5) if_addr = 16'h0060;
            @(negedge clk);
            checks++;
            if (if_done !== (c == 9) || mem_enable !== (c == 0 || c == 5)
                || mem_addr !== ((c < 5) ? 16'h0050 : 16'h0060)) begin
                errors++;
                $display("FAIL cancel c=%0d got done %b en %b addr %h", c, if_done, mem_enable, mem_addr);
            end
            next_cycle();
        end
        if_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
        for (int c = 0; c <= 7; c++) begin
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_enable !== (c == 0 || c == 3) || d_done !== (c == 7) || d_stall !== (c != 2 && c != 7)) begin
                errors++;
                $display("FAIL reset_mid c=%0d got en %b done %b stall %b", c, mem_enable, d_done, d_stall);
            end
            next_cycle();
        end
        d_req = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_write();
        test_cancel();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
